// File: rtl/cic_pkg.sv
// Shared CIC filter definitions, used by both the RX decimator and the TX interpolator.
// It holds the accumulator width helper, the default stage/ratio settings and the output scaling shift.
package cic_pkg;

    localparam int NUM_STAGES_DEF = 3;
    localparam int STG_GSZ_DEF    = 8;
    localparam int ISZ_DEF        = 16;
    localparam int OSZ_DEF        = 16;

    // Full Hogenauer growth: every stage adds log2(R) bits, so the integrators never lose information.
    function automatic int cic_asz(input int isz, input int n, input int g);
        return isz + n * g;
    endfunction

    // Right shift that maps the full-precision comb output onto the output word.
    function automatic int cic_shift(input int asz, input int osz);
        return asz - osz;
    endfunction

    localparam int SCALE_SHIFT_DEF =
        cic_shift(cic_asz(ISZ_DEF, NUM_STAGES_DEF, STG_GSZ_DEF), OSZ_DEF);

endpackage

// File: rtl/cic_decimator_if.sv
// Sample-stream bundle for the CIC decimator.
// The source side (ADC/DDC) drives the input strobe and sample. The decimator returns the output strobe and sample.
interface cic_decimator_if #(
    parameter int ISZ = 16,
    parameter int OSZ = 16
);
    logic                  in_rate;
    logic signed [ISZ-1:0] in;
    logic                  out_rate;
    logic signed [OSZ-1:0] out;

    modport master (output in_rate, output in, input out_rate, input out);
    modport slave  (input in_rate, input in, output out_rate, output out);
endinterface

// File: rtl/cic_comb_stage.sv
// One comb section with differential delay 1. It updates only on its enable pulse,
// so it advances at the decimated rate.
module cic_comb_stage #(
    parameter int ASZ = 40
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic signed [ASZ-1:0] x,
    output logic signed [ASZ-1:0] diff
);
    logic signed [ASZ-1:0] dly;

    // diff = x[n] - x[n-1], taken at the output rate
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            diff <= '0;
            dly  <= '0;
        end else if (en) begin
            diff <= x - dly;
            dly  <= x;
        end
    end
endmodule

// File: rtl/cic_decimator.sv
// N-stage CIC decimator with R = 2^STG_GSZ. The integrators run on in_rate. The combs ripple through
// one stage per clk after each decimation point, so the output appears N+1 clks after the decimating strobe.
// Optional build macro: CIC_DECIMATOR_ROUND_EN selects round-half-up with positive saturation.
// Without it the output is a plain truncation of the comb result.
module cic_decimator
    import cic_pkg::*;
#(
    parameter int NUM_STAGES = NUM_STAGES_DEF,
    parameter int STG_GSZ    = STG_GSZ_DEF,
    parameter int ISZ        = ISZ_DEF,
    parameter int OSZ        = OSZ_DEF
) (
    input  logic clk,
    input  logic reset_n,
    cic_decimator_if.slave bus
);
    localparam int ASZ   = cic_asz(ISZ, NUM_STAGES, STG_GSZ);
    localparam int SHIFT = cic_shift(ASZ, OSZ);

    logic signed [ASZ-1:0] in_ext;
    logic signed [ASZ-1:0] integ [NUM_STAGES];
    logic [STG_GSZ-1:0]    cnt;
    logic                  dec_hit;
    logic signed [ASZ-1:0] comb_in;
    logic [NUM_STAGES:0]   en;
    logic signed [ASZ-1:0] stage_out [NUM_STAGES];
    logic signed [ASZ-1:0] comb_out;
    logic signed [OSZ-1:0] scaled;

    assign in_ext  = ASZ'(bus.in);
    assign dec_hit = bus.in_rate && (cnt == '1);

    // Integrator chain: each stage accumulates the previous stage's registered value, modulo 2^ASZ
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_STAGES; i++) integ[i] <= '0;
        end else if (bus.in_rate) begin
            integ[0] <= integ[0] + in_ext;
            for (int i = 1; i < NUM_STAGES; i++) integ[i] <= integ[i] + integ[i-1];
        end
    end

    // Decimation counter. The R-th strobe of each frame hands the last integrator to the combs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            comb_in <= '0;
        end else begin
            if (bus.in_rate) cnt <= cnt + STG_GSZ'(1);
            if (dec_hit)     comb_in <= integ[NUM_STAGES-1];
        end
    end

    // Comb enable ripple, independent of in_rate, so strobes during the ripple are harmless
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) en <= '0;
        else          en <= {en[NUM_STAGES-1:0], dec_hit};
    end

    for (genvar j = 0; j < NUM_STAGES; j++) begin : g_comb
        if (j == 0) begin : g_first
            cic_comb_stage #(.ASZ(ASZ)) u_stage (
                .clk(clk), .reset_n(reset_n), .en(en[0]),
                .x(comb_in), .diff(stage_out[0])
            );
        end else begin : g_next
            cic_comb_stage #(.ASZ(ASZ)) u_stage (
                .clk(clk), .reset_n(reset_n), .en(en[j]),
                .x(stage_out[j-1]), .diff(stage_out[j])
            );
        end
    end

    assign comb_out = stage_out[NUM_STAGES-1];

`ifdef CIC_DECIMATOR_ROUND_EN
    localparam logic signed [ASZ:0] RND_HALF = (ASZ+1)'(1) <<< (SHIFT - 1);
    logic signed [ASZ:0] rnd_sum;
    logic signed [OSZ:0] rnd_q;

    // Round half up. Only the upward add can overflow, so only positive full-scale needs clamping
    always_comb begin
        rnd_sum = (ASZ+1)'(comb_out) + RND_HALF;
        rnd_q   = (OSZ+1)'(rnd_sum >>> SHIFT);
        scaled  = rnd_q[OSZ-1:0];
        if (rnd_q[OSZ] != rnd_q[OSZ-1]) scaled = {1'b0, {(OSZ-1){1'b1}}};
    end
`else
    // Floor: keep the top OSZ bits of the full-precision result
    always_comb begin
        scaled = OSZ'(comb_out >>> SHIFT);
    end
`endif

    // Output register: one-clk strobe, sample held until the next decimated result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.out      <= '0;
            bus.out_rate <= 1'b0;
        end else begin
            bus.out_rate <= en[NUM_STAGES];
            if (en[NUM_STAGES]) bus.out <= scaled;
        end
    end
endmodule

// File: tb/tb_cic_decimator.sv
// Directed bench for cic_decimator. It runs a 16-bit-output instance and an 8-bit-output instance
// on the same input stream. It checks DC gain, decimated timing, impulse response, mid-frame reset
// and output scaling in both the truncating and the rounding build.
module tb_cic_decimator;
    localparam int N = 3;
    localparam int G = 8;
    localparam int R = 1 << G;
`ifdef CIC_DECIMATOR_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    typedef struct {
        string name;
        int    value;
        int    period;
        int    exp16;
        int    exp8;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic in_rate = 1'b0;
    logic signed [15:0] din = '0;
    int total = 0;
    int bad = 0;

    cic_decimator_if #(.ISZ(16), .OSZ(16)) bus16 ();
    cic_decimator_if #(.ISZ(16), .OSZ(8))  bus8 ();

    assign bus16.in_rate = in_rate;
    assign bus16.in      = din;
    assign bus8.in_rate  = in_rate;
    assign bus8.in       = din;

    cic_decimator #(.NUM_STAGES(N), .STG_GSZ(G), .ISZ(16), .OSZ(16)) dut16 (
        .clk(clk), .reset_n(reset_n), .bus(bus16));
    cic_decimator #(.NUM_STAGES(N), .STG_GSZ(G), .ISZ(16), .OSZ(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .bus(bus8));

    always #5 clk = ~clk;

    task automatic check(input string what, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", what, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_rate = 1'b0;
        din = '0;
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    function automatic longint choose(input longint n, input int k);
        longint r = 1;
        if (n < 0 || n < k) return 0;
        for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
        return r;
    endfunction

    // Captured integrator value at decimation m for a unit impulse on the first strobe
    function automatic longint v_imp(input int m);
        longint n = longint'(m) * R - N;
        if (n < 1) return 0;
        return choose(n + N - 2, N - 1);
    endfunction

    // Expected 16-bit output number m for an impulse of height x
    function automatic int imp_out(input int m, input int x);
        longint y = 0;
        longint sh = 24;
        for (int k = 0; k <= N; k++)
            y += ((k % 2) ? -1 : 1) * choose(N, k) * v_imp(m - k);
        y = y * x;
        if (RND) y += longint'(1) <<< (sh - 1);
        return int'(y >>> sh);
    endfunction

    task automatic run_dc(input vec_t v);
        int pulses = 0;
        int last = 0;
        int first = -1;
        int held = 0;
        int wide = 0;
        int unstable = 0;
        bit prev = 1'b0;
        do_reset();
        check({v.name, " reset out16"}, int'(bus16.out), 0);
        check({v.name, " reset out_rate"}, int'(bus16.out_rate), 0);
        for (int cyc = 0; cyc < 7 * R * v.period + 64 && pulses < 6; cyc++) begin
            @(negedge clk);
            if (bus16.out_rate) begin
                pulses++;
                if (prev) wide++;
                if (pulses == 1) first = cyc;
                else check($sformatf("%s spacing %0d", v.name, pulses), cyc - last, R * v.period);
                last = cyc;
                held = int'(bus16.out);
                if (pulses > N) begin
                    check($sformatf("%s out16 #%0d", v.name, pulses), int'(bus16.out), v.exp16);
                    check($sformatf("%s out8 #%0d", v.name, pulses), int'(bus8.out), v.exp8);
                end
            end else if (pulses > 0 && int'(bus16.out) != held) begin
                unstable++;
            end
            prev = bus16.out_rate;
            in_rate = ((cyc % v.period) == 0);
            din = 16'(v.value);
        end
        in_rate = 1'b0;
        check({v.name, " pulse count"}, pulses, 6);
        check({v.name, " first latency"}, first, (R - 1) * v.period + N + 2);
        check({v.name, " pulse width"}, wide, 0);
        check({v.name, " out held"}, unstable, 0);
    endtask

    vec_t vecs [6];

    initial begin
        int pulses;
        int first;
        vecs[0] = '{"dc_pos",    1000,   1, 1000,   RND ? 4 : 3};
        vecs[1] = '{"dc_negfs", -32768,  1, -32768, -128};
        vecs[2] = '{"dc_posfs",  32767,  1, 32767,  127};
        vecs[3] = '{"dc_neg",   -1000,   1, -1000,  -4};
        vecs[4] = '{"dc_m1",    -1,      1, -1,     RND ? 0 : -1};
        vecs[5] = '{"strobe3",   1000,   3, 1000,   RND ? 4 : 3};

        for (int i = 0; i < 6; i++) run_dc(vecs[i]);

        // Impulse: single full-scale sample, then zeros
        do_reset();
        pulses = 0;
        for (int cyc = 0; cyc < 7 * R + 64 && pulses < 6; cyc++) begin
            @(negedge clk);
            if (bus16.out_rate) begin
                pulses++;
                check($sformatf("impulse out #%0d", pulses), int'(bus16.out), imp_out(pulses, 32767));
            end
            in_rate = 1'b1;
            din = (cyc == 0) ? 16'sd32767 : 16'sd0;
        end
        in_rate = 1'b0;
        check("impulse pulse count", pulses, 6);

        // Reset in the middle of a frame after the output has gone non-zero
        do_reset();
        for (int cyc = 0; cyc < 3 * R + 100; cyc++) begin
            @(negedge clk);
            in_rate = 1'b1;
            din = 16'sd1000;
        end
        @(negedge clk);
        in_rate = 1'b0;
        check("pre-reset out16 nonzero", int'(bus16.out != 0), 1);
        reset_n = 1'b0;
        #1;
        check("midreset out16", int'(bus16.out), 0);
        check("midreset out8", int'(bus8.out), 0);
        check("midreset out_rate", int'(bus16.out_rate), 0);
        @(negedge clk);
        reset_n = 1'b1;
        first = -1;
        for (int cyc = 0; cyc < R + 40 && first < 0; cyc++) begin
            @(negedge clk);
            if (bus16.out_rate) first = cyc;
            in_rate = 1'b1;
            din = 16'sd1000;
        end
        in_rate = 1'b0;
        check("after reset first pulse", first, (R - 1) + N + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
